// File: rtl/y86_fetch_unit_if.sv
// Fetch-stage bus: hazard/redirect inputs, imem load port and decoded fetch outputs.
interface y86_fetch_unit_if #(
  parameter int WR_BYTES = 1
);
  logic                    F_stall;
  logic [3:0]              M_icode;
  logic                    M_cnd;
  logic [63:0]             M_valA;
  logic [3:0]              W_icode;
  logic [63:0]             W_valM;
  logic                    imem_we;
  logic [63:0]             imem_waddr;
  logic [8*WR_BYTES-1:0]   imem_wdata;
  logic [63:0]             f_pc;
  logic [3:0]              f_icode;
  logic [3:0]              f_ifun;
  logic [3:0]              f_rA;
  logic [3:0]              f_rB;
  logic [63:0]             f_valC;
  logic [63:0]             f_valP;
  logic [3:0]              f_stat;
  logic [63:0]             F_predPC;
  logic                    halted;

  modport master (
    output F_stall, M_icode, M_cnd, M_valA, W_icode, W_valM,
           imem_we, imem_waddr, imem_wdata,
    input  f_pc, f_icode, f_ifun, f_rA, f_rB, f_valC, f_valP, f_stat,
           F_predPC, halted
  );

  modport slave (
    input  F_stall, M_icode, M_cnd, M_valA, W_icode, W_valM,
           imem_we, imem_waddr, imem_wdata,
    output f_pc, f_icode, f_ifun, f_rA, f_rB, f_valC, f_valP, f_stat,
           F_predPC, halted
  );
endinterface

// File: rtl/y86_fetch_unit.sv
// Y86-64 PIPE fetch stage: F register, PC select, byte-wide imem, field split,
// next-PC prediction and a sticky halt/error state that a redirect can cancel.
module y86_fetch_unit #(
  parameter int          IMEM_BYTES = 1024,
  parameter logic [63:0] RESET_PC   = 64'd0,
  parameter int          WR_BYTES   = 1
) (
  input logic              clk,
  input logic              reset,
  y86_fetch_unit_if.slave  bus
);
  localparam int          AW    = (IMEM_BYTES > 1) ? $clog2(IMEM_BYTES) : 1;
  localparam logic [64:0] LIMIT = 65'(IMEM_BYTES);

  localparam logic [3:0] S_AOK = 4'd1;
  localparam logic [3:0] S_HLT = 4'd2;
  localparam logic [3:0] S_ADR = 4'd3;
  localparam logic [3:0] S_INS = 4'd4;

  typedef enum logic {RUN, HALTED} state_t;

  state_t      r_state, w_state_nxt;
  logic [63:0] r_predPC, w_predPC_nxt;
  logic [3:0]  r_stat, w_stat_nxt;

  logic [7:0]  r_mem [IMEM_BYTES];

  // Load port: each byte of the beat is range-checked on its own, so a beat
  // straddling the end of memory keeps its in-range bytes.
  always_ff @(posedge clk) begin
    if (bus.imem_we) begin
      for (int i = 0; i < WR_BYTES; i++) begin
        if (({1'b0, bus.imem_waddr} + 65'(i)) < LIMIT)
          r_mem[AW'(bus.imem_waddr + 64'(i))] <= bus.imem_wdata[8*i +: 8];
      end
    end
  end

  // PC select: ret in W beats a mispredicted jump in M, which beats the prediction.
  logic        w_ret, w_misp, w_redirect;
  logic [63:0] w_pc;
  assign w_ret      = (bus.W_icode == 4'h9);
  assign w_misp     = (bus.M_icode == 4'h7) && !bus.M_cnd;
  assign w_redirect = w_ret || w_misp;
  assign w_pc       = w_ret ? bus.W_valM : (w_misp ? bus.M_valA : r_predPC);

  // Ten instruction bytes starting at the PC; out-of-range bytes read as 0
  // (the instruction is flagged ADR in that case anyway).
  logic [64:0] w_baddr [10];
  logic [7:0]  w_byte  [10];
  for (genvar k = 0; k < 10; k++) begin : g_rd
    assign w_baddr[k] = {1'b0, w_pc} + 65'(k);
    assign w_byte[k]  = (w_baddr[k] < LIMIT) ? r_mem[w_baddr[k][AW-1:0]] : 8'h00;
  end

  logic [3:0]  w_icode, w_ifun;
  logic [3:0]  w_len;
  logic        w_icode_ok, w_ifun_ok, w_regs, w_valc2, w_valc1;
  logic [64:0] w_end;
  logic        w_adr, w_ins;

  assign w_icode = w_byte[0][7:4];
  assign w_ifun  = w_byte[0][3:0];

  // Length, field presence and ifun legality per icode.
  always_comb begin
    w_len      = 4'd1;
    w_icode_ok = 1'b1;
    w_ifun_ok  = (w_ifun == 4'h0);
    w_regs     = 1'b0;
    w_valc2    = 1'b0;
    w_valc1    = 1'b0;
    case (w_icode)
      4'h0, 4'h1, 4'h9: w_len = 4'd1;
      4'h2: begin w_len = 4'd2;  w_regs = 1'b1; w_ifun_ok = (w_ifun <= 4'd6); end
      4'h3, 4'h4, 4'h5: begin w_len = 4'd10; w_regs = 1'b1; w_valc2 = 1'b1; end
      4'h6: begin w_len = 4'd2;  w_regs = 1'b1; w_ifun_ok = (w_ifun <= 4'd3); end
      4'h7: begin w_len = 4'd9;  w_valc1 = 1'b1; w_ifun_ok = (w_ifun <= 4'd6); end
      4'h8: begin w_len = 4'd9;  w_valc1 = 1'b1; end
      4'hA, 4'hB: begin w_len = 4'd2; w_regs = 1'b1; end
      default: begin w_len = 4'd1; w_icode_ok = 1'b0; end
    endcase
  end

  // 65-bit end address so an instruction near 2^64 cannot wrap back into range.
  assign w_end = {1'b0, w_pc} + 65'(w_len) - 65'd1;
  assign w_adr = (w_end >= LIMIT) || ({1'b0, w_pc} >= LIMIT);
  assign w_ins = !w_icode_ok || !w_ifun_ok;

  logic        w_bubble;
  logic [63:0] w_predPC;
  assign w_bubble = (r_state == HALTED) && !w_redirect;

  // Output decode: frozen bubble while halted, nop bubble on ADR/INS, else fields.
  always_comb begin
    bus.f_pc    = w_pc;
    bus.f_icode = 4'h1;
    bus.f_ifun  = 4'h0;
    bus.f_rA    = 4'hF;
    bus.f_rB    = 4'hF;
    bus.f_valC  = 64'd0;
    bus.f_valP  = w_pc;
    bus.f_stat  = S_AOK;
    if (w_bubble) begin
      bus.f_stat = r_stat;
    end else if (w_adr) begin
      bus.f_stat = S_ADR;
    end else if (w_ins) begin
      bus.f_stat = S_INS;
    end else begin
      bus.f_icode = w_icode;
      bus.f_ifun  = w_ifun;
      if (w_regs) begin
        bus.f_rA = w_byte[1][7:4];
        bus.f_rB = w_byte[1][3:0];
      end
      if (w_valc2)
        bus.f_valC = {w_byte[9], w_byte[8], w_byte[7], w_byte[6],
                      w_byte[5], w_byte[4], w_byte[3], w_byte[2]};
      else if (w_valc1)
        bus.f_valC = {w_byte[8], w_byte[7], w_byte[6], w_byte[5],
                      w_byte[4], w_byte[3], w_byte[2], w_byte[1]};
      bus.f_valP = w_pc + 64'(w_len);
      bus.f_stat = (w_icode == 4'h0) ? S_HLT : S_AOK;
    end
  end

  assign w_predPC     = ((bus.f_icode == 4'h7) || (bus.f_icode == 4'h8)) ? bus.f_valC : bus.f_valP;
  assign bus.F_predPC = r_predPC;
  assign bus.halted   = (r_state == HALTED);

  // Next state: stall freezes everything; a halted fetch only moves on a redirect.
  always_comb begin
    w_state_nxt  = r_state;
    w_predPC_nxt = r_predPC;
    w_stat_nxt   = r_stat;
    if (!bus.F_stall && !w_bubble) begin
      w_predPC_nxt = w_predPC;
      if (bus.f_stat != S_AOK) begin
        w_state_nxt = HALTED;
        w_stat_nxt  = bus.f_stat;
      end else begin
        w_state_nxt = RUN;
      end
    end
  end

  // F register and halt state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= RUN;
      r_predPC <= RESET_PC;
      r_stat   <= S_AOK;
    end else begin
      r_state  <= w_state_nxt;
      r_predPC <= w_predPC_nxt;
      r_stat   <= w_stat_nxt;
    end
  end
endmodule
